// File: rtl/keypad_pkg.sv
// Keypad shared types and helpers.
// Also used by the time-set logic.
package keypad_pkg;

  localparam int NROWS = 4;
  localparam int NCOLS = 4;
  localparam int KEY_W = 4;

  typedef logic [KEY_W-1:0] key_code_t;

  function automatic key_code_t key_enc(
    input logic [1:0] row,
    input logic [1:0] col
  );
    return {row, col};
  endfunction

  // Saturates at 7; callers only need 0, 1 or many.
  function automatic logic [2:0] popcount16(
    input logic [15:0] v
  );
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < 16; i++)
      n = n + 5'(v[i]);
    return (n > 5'd7) ? 3'd7 : n[2:0];
  endfunction

  function automatic key_code_t onehot16_to_idx(
    input logic [15:0] v
  );
    key_code_t idx;
    idx = '0;
    for (int i = 0; i < 16; i++)
      if (v[i]) idx = idx | KEY_W'(i);
    return idx;
  endfunction

endpackage

// File: rtl/keypad_matrix_scanner_input_sync.sv
// Two-flop synchronizer for asynchronous inputs.
// Resets to the idle (pulled-up) level.
module input_sync #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_matrix_scanner.sv
// 4x4 keypad scanner: row drive, debounced full-scan
// snapshots and single-key press events.
module keypad_matrix_scanner
  import keypad_pkg::*;
#(
  parameter int SETTLE   = 4,
  parameter int DEBOUNCE = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] cols_n,
  output logic [3:0] rows_n,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       key_down,
  output logic       multi
);

  localparam int DW = $clog2(SETTLE);
  localparam int CW = $clog2(DEBOUNCE + 1);

  logic [3:0]    cols_sync;
  logic          run;
  logic [1:0]    row, row_nxt;
  logic [DW-1:0] dwell, dwell_nxt;
  logic          last_dwell;
  logic [15:0]   snapshot, snap_nxt;
  logic [15:0]   prev, prev_nxt;
  logic [15:0]   accepted, acc_nxt;
  logic [15:0]   acc_d;
  logic [CW-1:0] stable_cnt, cnt_nxt;
  logic [2:0]    pc;

  input_sync #(.WIDTH(4)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (cols_n),
    .q   (cols_sync)
  );

  assign last_dwell = run && (dwell == DW'(SETTLE - 1));

  // First cycle after reset only starts row 0 without advancing.
  always_comb begin
    row_nxt   = row;
    dwell_nxt = dwell;
    if (run) begin
      if (last_dwell) begin
        dwell_nxt = '0;
        row_nxt   = row + 2'd1;
      end else begin
        dwell_nxt = dwell + DW'(1);
      end
    end
  end

  always_comb begin
    snap_nxt = snapshot;
    prev_nxt = prev;
    cnt_nxt  = stable_cnt;
    acc_nxt  = accepted;
    if (last_dwell)
      for (int c = 0; c < NCOLS; c++)
        snap_nxt[key_enc(row, 2'(c))] = ~cols_sync[c];
    if (last_dwell && row == 2'd3) begin
      if (snap_nxt == prev) begin
        if (stable_cnt != CW'(DEBOUNCE))
          cnt_nxt = stable_cnt + CW'(1);
      end else begin
        prev_nxt = snap_nxt;
        cnt_nxt  = CW'(1);
      end
      if (cnt_nxt == CW'(DEBOUNCE))
        acc_nxt = snap_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run        <= 1'b0;
      row        <= '0;
      dwell      <= '0;
      rows_n     <= 4'hF;
      snapshot   <= '0;
      prev       <= '0;
      stable_cnt <= '0;
      accepted   <= '0;
    end else begin
      run        <= 1'b1;
      row        <= row_nxt;
      dwell      <= dwell_nxt;
      rows_n     <= ~(4'b0001 << row_nxt);
      snapshot   <= snap_nxt;
      prev       <= prev_nxt;
      stable_cnt <= cnt_nxt;
      accepted   <= acc_nxt;
    end
  end

  assign pc = popcount16(accepted);

  // acc_d differs from accepted only in the cycle after an update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_d     <= '0;
      key_valid <= 1'b0;
      key_code  <= '0;
      key_down  <= 1'b0;
      multi     <= 1'b0;
    end else begin
      acc_d     <= accepted;
      key_down  <= (pc == 3'd1);
      multi     <= (pc >= 3'd2);
      key_valid <= (pc == 3'd1) && (accepted != acc_d);
      if ((pc == 3'd1) && (accepted != acc_d))
        key_code <= onehot16_to_idx(accepted);
    end
  end

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Directed bench for keypad_matrix_scanner with a
// behavioural key-matrix model.
module tb_keypad_matrix_scanner;

  localparam int SETTLE   = 3;
  localparam int DEBOUNCE = 3;
  localparam int LAT      = 51;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  cols_n;
  logic [3:0]  rows_n;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_down;
  logic        multi;
  logic [15:0] keys = '0;

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  always #5 clk = ~clk;

  keypad_matrix_scanner #(
    .SETTLE   (SETTLE),
    .DEBOUNCE (DEBOUNCE)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cols_n    (cols_n),
    .rows_n    (rows_n),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_down  (key_down),
    .multi     (multi)
  );

  always_comb begin
    cols_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !rows_n[r])
          cols_n[c] = 1'b0;
  end

  always @(negedge clk)
    if (key_valid) pulses++;

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_pulse(input int base, input int budget,
                            output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      tick();
      if (pulses > base) ok = 1'b1;
    end
  endtask

  task automatic wait_down(input logic want, input int budget,
                           output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      tick();
      if (key_down === want) ok = 1'b1;
    end
  endtask

  task automatic release_all(input string tag);
    bit ok;
    keys = '0;
    wait_down(1'b0, LAT, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s release: key_down=%b required 0", tag, key_down);
    end
  endtask

  task automatic test_reset();
    logic [3:0] one;
    logic [3:0] exp;
    one = 4'b0001;
    rst = 1'b1;
    keys = '0;
    repeat (3) tick();
    checks++;
    if (rows_n !== 4'hF) begin
      errors++;
      $display("FAIL reset_rows: got %b required 1111", rows_n);
    end
    checks++;
    if ({key_valid, key_code, key_down, multi} !== 7'd0) begin
      errors++;
      $display("FAIL reset_outs: got v=%b c=%h d=%b m=%b required 0",
               key_valid, key_code, key_down, multi);
    end
    rst = 1'b0;
    for (int i = 0; i < 24; i++) begin
      tick();
      exp = ~(one << ((i / 3) % 4));
      checks++;
      if (rows_n !== exp) begin
        errors++;
        $display("FAIL scan_rows[%0d]: got %b required %b", i, rows_n, exp);
      end
    end
  endtask

  task automatic test_single_key();
    int base;
    bit ok;
    base = pulses;
    keys = 16'h0200;
    wait_pulse(base, LAT, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL single_press: no key_valid within %0d cycles", LAT);
    end
    checks++;
    if (key_code !== 4'h9 || key_down !== 1'b1 || multi !== 1'b0) begin
      errors++;
      $display("FAIL single_code: got c=%h d=%b m=%b required 9 1 0",
               key_code, key_down, multi);
    end
    tick();
    checks++;
    if (key_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_width: key_valid=%b required 0", key_valid);
    end
    repeat (30) tick();
    checks++;
    if (pulses - base != 1) begin
      errors++;
      $display("FAIL single_count: got %0d pulses required 1", pulses - base);
    end
    base = pulses;
    release_all("single");
    repeat (30) tick();
    checks++;
    if (pulses != base || key_code !== 4'h9) begin
      errors++;
      $display("FAIL single_open: got %0d pulses code %h required 0 and 9",
               pulses - base, key_code);
    end
  endtask

  task automatic test_bounce();
    int base;
    base = pulses;
    for (int k = 0; k < 5; k++) begin
      keys[6] = ~keys[6];
      repeat (12) tick();
    end
    repeat (LAT + 10) tick();
    checks++;
    if (pulses - base != 1) begin
      errors++;
      $display("FAIL bounce_count: got %0d pulses required 1", pulses - base);
    end
    checks++;
    if (key_code !== 4'h6 || key_down !== 1'b1) begin
      errors++;
      $display("FAIL bounce_code: got c=%h d=%b required 6 1",
               key_code, key_down);
    end
    release_all("bounce");
  endtask

  task automatic test_multi();
    int base;
    bit ok;
    base = pulses;
    keys = 16'h0021;
    repeat (LAT + 10) tick();
    checks++;
    if (multi !== 1'b1 || key_down !== 1'b0) begin
      errors++;
      $display("FAIL multi_level: got m=%b d=%b required 1 0",
               multi, key_down);
    end
    checks++;
    if (pulses != base || key_code !== 4'h6) begin
      errors++;
      $display("FAIL multi_hold: got %0d pulses code %h required 0 and 6",
               pulses - base, key_code);
    end
    keys = 16'h0001;
    wait_pulse(base, LAT, ok);
    checks++;
    if (!ok || key_code !== 4'h0 || key_down !== 1'b1 || multi !== 1'b0) begin
      errors++;
      $display("FAIL multi_release: got ok=%b c=%h d=%b m=%b required 1 0 1 0",
               ok, key_code, key_down, multi);
    end
    release_all("multi");
  endtask

  task automatic test_back_to_back();
    int base;
    bit ok;
    base = pulses;
    keys = 16'h0008;
    wait_pulse(base, LAT, ok);
    checks++;
    if (!ok || key_code !== 4'h3) begin
      errors++;
      $display("FAIL swap_first: got ok=%b code %h required 1 3", ok, key_code);
    end
    repeat (5) tick();
    keys = 16'h1000;
    wait_pulse(base + 1, LAT, ok);
    checks++;
    if (!ok || key_code !== 4'hC) begin
      errors++;
      $display("FAIL swap_second: got ok=%b code %h required 1 c", ok, key_code);
    end
    repeat (30) tick();
    checks++;
    if (pulses - base != 2) begin
      errors++;
      $display("FAIL swap_count: got %0d pulses required 2", pulses - base);
    end
    release_all("swap");
  endtask

  task automatic test_reset_mid();
    int base;
    bit ok;
    base = pulses;
    keys = 16'h0200;
    wait_pulse(base, LAT, ok);
    checks++;
    if (!ok || key_code !== 4'h9) begin
      errors++;
      $display("FAIL rmid_press: got ok=%b code %h required 1 9", ok, key_code);
    end
    repeat (4) tick();
    rst = 1'b1;
    #1;
    checks++;
    if (rows_n !== 4'hF ||
        {key_valid, key_code, key_down, multi} !== 7'd0) begin
      errors++;
      $display("FAIL rmid_clear: got r=%b v=%b c=%h d=%b m=%b required all clear",
               rows_n, key_valid, key_code, key_down, multi);
    end
    repeat (3) tick();
    base = pulses;
    rst = 1'b0;
    wait_pulse(base, LAT + 2, ok);
    checks++;
    if (!ok || key_code !== 4'h9 || key_down !== 1'b1) begin
      errors++;
      $display("FAIL rmid_again: got ok=%b c=%h d=%b required 1 9 1",
               ok, key_code, key_down);
    end
    release_all("rmid");
  endtask

  initial begin
    test_reset();
    test_single_key();
    test_bounce();
    test_multi();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
